// File: rtl/stream_arbiter.sv
// Round-robin packet arbiter: merges PORTS ready/valid streams into one registered output.
// Holds the grant on a port until a last beat is accepted (LOCK_PACKETS=1).

module stream_arbiter_lane (
  input  logic gnt_i,
  input  logic en_i,
  input  logic valid_i,
  input  logic rst_i,
  output logic ready_o,
  output logic acc_o
);
  assign ready_o = gnt_i & en_i & ~rst_i;
  assign acc_o   = ready_o & valid_i;
endmodule

module stream_arbiter #(
  parameter int PORTS        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ID_WIDTH     = (PORTS > 1) ? $clog2(PORTS) : 1,
  parameter bit LOCK_PACKETS = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [PORTS-1:0]                     stream_in_valid_i,
  output logic [PORTS-1:0]                     stream_in_ready_o,
  input  logic [PORTS-1:0][DATA_WIDTH-1:0]     stream_in_data_i,
  input  logic [PORTS-1:0]                     in_last_i,
  output logic                                 stream_out_valid_o,
  input  logic                                 stream_out_ready_i,
  output logic [DATA_WIDTH-1:0]                stream_out_data_o,
  output logic                                 stream_out_last_o,
  output logic [ID_WIDTH-1:0]                  stream_out_id_o
);

  if (PORTS < 2) begin : g_chk_ports
    $error("stream_arbiter: PORTS must be at least 2");
  end
  if (ID_WIDTH < $clog2(PORTS)) begin : g_chk_idw
    $error("stream_arbiter: ID_WIDTH too narrow for PORTS");
  end

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_last_q,  out_last_d;
  logic [ID_WIDTH-1:0]   out_id_q,    out_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q,    rr_ptr_d;
  logic                  locked_q,    locked_d;
  logic [ID_WIDTH-1:0]   lock_id_q,   lock_id_d;

  logic                  enable;
  logic                  gnt_vld;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [ID_WIDTH-1:0]   idx;
  logic [ID_WIDTH-1:0]   next_rr;
  logic [PORTS-1:0]      acc;
  logic                  accept;

  assign enable = !out_valid_q || stream_out_ready_i;

  // Scan from the farthest offset down so the port closest to rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (locked_q) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else begin
      for (int k = PORTS - 1; k >= 0; k--) begin
        idx = ID_WIDTH'((int'(rr_ptr_q) + k) % PORTS);
        if (stream_in_valid_i[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    stream_arbiter_lane u_lane (
      .gnt_i   (gnt_vld && (gnt_id == ID_WIDTH'(p))),
      .en_i    (enable),
      .valid_i (stream_in_valid_i[p]),
      .rst_i   (rst),
      .ready_o (stream_in_ready_o[p]),
      .acc_o   (acc[p])
    );
  end

  assign accept  = |acc;
  assign next_rr = (gnt_id == ID_WIDTH'(PORTS - 1)) ? '0 : gnt_id + ID_WIDTH'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    locked_d    = locked_q;
    lock_id_d   = lock_id_q;
    if (enable) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = stream_in_data_i[gnt_id];
        out_last_d = in_last_i[gnt_id];
        out_id_d   = gnt_id;
        if (LOCK_PACKETS && !in_last_i[gnt_id]) begin
          locked_d  = 1'b1;
          lock_id_d = gnt_id;
        end else begin
          locked_d  = 1'b0;
          rr_ptr_d  = next_rr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      locked_q    <= 1'b0;
      lock_id_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      locked_q    <= locked_d;
      lock_id_q   <= lock_id_d;
    end
  end

  assign stream_out_valid_o = out_valid_q;
  assign stream_out_data_o  = out_data_q;
  assign stream_out_last_o  = out_last_q;
  assign stream_out_id_o    = out_id_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter (PORTS=4): cycle vector table, then scoreboarded packet sequences.

module tb_stream_arbiter;

  typedef struct packed {
    logic [3:0] vld;
    logic [3:0] lst;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] id;
    logic       last;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } src_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic            clk, rst;
  logic [3:0]      vld, rdy, lst;
  logic [3:0][7:0] dat;
  logic            ov, ordy, olast;
  logic [7:0]      odata;
  logic [1:0]      oid;

  int    tests = 0;
  int    fails = 0;
  src_t  src_q[4][$];
  beat_t exp_q[$];
  logic [3:0] en;
  logic  sb_on, bp_on;
  int    bp_idx;
  int    pat[6] = '{1, 0, 0, 1, 1, 0};
  logic  prev_stall;
  beat_t prev_beat;

  stream_arbiter #(.PORTS(4), .DATA_WIDTH(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .stream_in_valid_i  (vld),
    .stream_in_ready_o  (rdy),
    .stream_in_data_i   (dat),
    .in_last_i          (lst),
    .stream_out_valid_o (ov),
    .stream_out_ready_i (ordy),
    .stream_out_data_o  (odata),
    .stream_out_last_o  (olast),
    .stream_out_id_o    (oid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output-side monitor: scoreboard pop, stall stability, single-ready.
  always @(negedge clk) begin
    if (sb_on) begin
      chk("one_ready", ($countones(rdy) <= 1), 1);
      if (prev_stall) chk("stall_stable", {oid, odata, olast}, prev_beat);
      if (ov && ordy) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {oid, odata, olast}, 0);
        else chk("sb_beat", {oid, odata, olast}, exp_q.pop_front());
      end
      prev_stall = ov && !ordy;
      prev_beat  = {oid, odata, olast};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic src_busy();
    return (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) != 0;
  endfunction

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      if (src_q[p].size() > 0 && en[p]) begin
        vld[p] = 1'b1;
        dat[p] = src_q[p][0].data;
        lst[p] = src_q[p][0].last;
      end else begin
        vld[p] = 1'b0;
      end
    end
    ordy = bp_on ? (pat[bp_idx % 6] != 0) : 1'b1;
    bp_idx++;
    #1;
  endtask

  task automatic cycle();
    logic [3:0] hs;
    @(negedge clk);
    hs = vld & rdy;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) if (hs[p]) void'(src_q[p].pop_front());
    drive();
  endtask

  task automatic run(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || src_busy()) && n < max) begin
      cycle();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    sb_on = 1'b0;
    rst   = 1'b1;
    for (int p = 0; p < 4; p++) src_q[p].delete();
    exp_q.delete();
    en = 4'hF; bp_on = 1'b0; bp_idx = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_on = 1'b1;
    drive();
  endtask

  task automatic push(input int p, input logic [7:0] d, input logic l);
    src_q[p].push_back('{d, l});
    exp_q.push_back('{2'(p), d, l});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[10];
    int   n;
    logic [7:0] ed;
    tv[0] = '{4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tv[1] = '{4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tv[2] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1};
    tv[3] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tv[4] = '{4'b0011, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tv[5] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tv[6] = '{4'b0101, 4'b1011, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tv[7] = '{4'b0001, 4'b1011, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0};
    tv[8] = '{4'b0101, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tv[9] = '{4'b0011, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};

    sb_on = 1'b0; bp_on = 1'b0; bp_idx = 0; en = 4'hF; prev_stall = 1'b0;
    rst = 1'b1; ordy = 1'b1; vld = 4'hF; lst = 4'hF;
    for (int p = 0; p < 4; p++) dat[p] = 8'hA0 + 8'(p);

    // Reset with every input valid
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_ready", rdy, 4'b0000);
      chk("rst_ov", ov, 0);
      chk("rst_id", oid, 0);
      chk("rst_data", odata, 0);
      chk("rst_last", olast, 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      vld = tv[i].vld; lst = tv[i].lst; ordy = tv[i].ordy;
      #1;
      chk($sformatf("tbl%0d_rdy", i), rdy, tv[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_ov", i), ov, tv[i].ov);
      if (tv[i].ov) begin
        ed = 8'hA0 + 8'(tv[i].id);
        chk($sformatf("tbl%0d_id", i), oid, tv[i].id);
        chk($sformatf("tbl%0d_last", i), olast, tv[i].last);
        chk($sformatf("tbl%0d_data", i), odata, ed);
      end
    end

    // Round-robin fairness, single-beat packets, full rate
    apply_reset();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 4; p++) push(p, 8'hA0 + 8'(p), 1'b1);
    drive();
    n = 0;
    while (src_busy() && n < 50) begin cycle(); n++; end
    chk("rr_rate", n, 12);
    run(10);

    // Packet lock: prime rr_ptr to 2 via port 1, then 3-beat packet on port 2
    apply_reset();
    push(1, 8'hB0, 1'b1);
    drive();
    run(20);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
    push(0, 8'hD0, 1'b1);
    push(1, 8'hB1, 1'b1);
    drive();
    run(30);

    // Mid-packet starvation on port 2
    apply_reset();
    push(1, 8'hB2, 1'b1);
    drive();
    run(20);
    push(2, 8'hE0, 1'b0); push(2, 8'hE1, 1'b0); push(2, 8'hE2, 1'b1);
    push(0, 8'hD1, 1'b1);
    push(1, 8'hB3, 1'b1);
    drive();
    n = 0;
    while (src_q[2].size() == 3 && n < 20) begin cycle(); n++; end
    chk("starve_first_beat", src_q[2].size(), 2);
    en[2] = 1'b0;
    drive();
    repeat (3) begin
      chk("starve_others_rdy", rdy & 4'b0011, 4'b0000);
      cycle();
      chk("starve_idle", ov, 0);
    end
    en[2] = 1'b1;
    drive();
    run(30);

    // Backpressure with 2-beat packets on every port
    apply_reset();
    bp_on = 1'b1;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 2; b++) push(p, 8'(8'h10 * p + b), (b == 1));
    drive();
    run(100);
    bp_on = 1'b0;

    // Reset after beat 1 of a 4-beat packet on port 1
    apply_reset();
    en[0] = 1'b0;
    push(1, 8'hF0, 1'b0);
    src_q[1].push_back('{8'hF1, 1'b0});
    src_q[1].push_back('{8'hF2, 1'b0});
    src_q[1].push_back('{8'hF3, 1'b1});
    src_q[0].push_back('{8'hD5, 1'b1});
    drive();
    n = 0;
    while (src_q[1].size() == 4 && n < 20) begin cycle(); n++; end
    chk("mid_first_beat", src_q[1].size(), 3);
    rst = 1'b1; en[0] = 1'b1;
    drive();
    chk("mid_rst_rdy", rdy, 4'b0000);
    repeat (2) begin
      cycle();
      chk("mid_rst_ov", ov, 0);
      chk("mid_rst_rdy2", rdy, 4'b0000);
    end
    exp_q.push_back('{2'd0, 8'hD5, 1'b1});
    exp_q.push_back('{2'd1, 8'hF1, 1'b0});
    exp_q.push_back('{2'd1, 8'hF2, 1'b0});
    exp_q.push_back('{2'd1, 8'hF3, 1'b1});
    rst = 1'b0;
    drive();
    chk("mid_post_rst_gnt", rdy, 4'b0001);
    run(30);

    sb_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
